// File: rtl/mdl_alignp_receive.sv
// ALIGNp link receiver model: samples the differential line, deserializes MSB-first,
// hunts for the ALIGNp pattern, verifies word alignment, and delivers words while locked.
module mdl_alignp_receive #(
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned UNLOCK_CNT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_en,
    input  logic        rx_p,
    input  logic        rx_n,
    input  logic [39:0] align_p,
    output logic [39:0] rx_word,
    output logic        rx_valid,
    output logic        align_det,
    output logic        locked,
    output logic        diff_err,
    output logic [15:0] align_cnt
);

    typedef enum logic [1:0] {S_HUNT, S_VERIFY, S_LOCKED} state_t;

    localparam logic [3:0] LOCK_N   = 4'(LOCK_CNT);
    localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_CNT);

    state_t      state_q, state_d;
    logic [39:0] win_q, win_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]  good_cnt_q, good_cnt_d;
    logic [3:0]  bad_cnt_q, bad_cnt_d;
    logic [39:0] rx_word_q, rx_word_d;
    logic        rx_valid_q, rx_valid_d;
    logic        align_det_q, align_det_d;
    logic        diff_err_q, diff_err_d;
    logic [15:0] align_cnt_q, align_cnt_d;

    logic        bit_smp;
    logic [39:0] next_win;
    logic        match;
    logic        boundary;

    // An invalid differential pair (both legs equal) is received as a 0.
    assign bit_smp  = (rx_p != rx_n) ? rx_p : 1'b0;
    assign next_win = {win_q[38:0], bit_smp};
    assign match    = (next_win == align_p);
    assign boundary = (bit_cnt_q == 6'd39);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_HUNT;
            win_q       <= '0;
            bit_cnt_q   <= '0;
            good_cnt_q  <= '0;
            bad_cnt_q   <= '0;
            rx_word_q   <= '0;
            rx_valid_q  <= 1'b0;
            align_det_q <= 1'b0;
            diff_err_q  <= 1'b0;
            align_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            bit_cnt_q   <= bit_cnt_d;
            good_cnt_q  <= good_cnt_d;
            bad_cnt_q   <= bad_cnt_d;
            rx_word_q   <= rx_word_d;
            rx_valid_q  <= rx_valid_d;
            align_det_q <= align_det_d;
            diff_err_q  <= diff_err_d;
            align_cnt_q <= align_cnt_d;
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the case leaves it unassigned and no latch is inferred.
        state_d    = state_q;
        win_d      = win_q;
        bit_cnt_d  = bit_cnt_q;
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        if (!rx_en) begin
            state_d    = S_HUNT;
            win_d      = '0;
            bit_cnt_d  = '0;
            good_cnt_d = '0;
            bad_cnt_d  = '0;
        end else begin
            win_d     = next_win;
            bit_cnt_d = boundary ? 6'd0 : bit_cnt_q + 6'd1;
            unique case (state_q)
                S_HUNT: begin
                    // A hunt match marks the last bit of a word, so the next sample is bit 0.
                    bit_cnt_d = '0;
                    if (match) begin
                        good_cnt_d = 4'd1;
                        bad_cnt_d  = '0;
                        state_d    = (LOCK_N == 4'd1) ? S_LOCKED : S_VERIFY;
                    end
                end
                S_VERIFY: begin
                    if (boundary) begin
                        if (match) begin
                            good_cnt_d = good_cnt_q + 4'd1;
                            if (good_cnt_q + 4'd1 == LOCK_N) begin
                                state_d   = S_LOCKED;
                                bad_cnt_d = '0;
                            end
                        end else begin
                            state_d    = S_HUNT;
                            good_cnt_d = '0;
                        end
                    end
                end
                S_LOCKED: begin
                    if (boundary) begin
                        if (match) begin
                            bad_cnt_d = '0;
                        end else if (bad_cnt_q + 4'd1 == UNLOCK_N) begin
                            state_d    = S_HUNT;
                            good_cnt_d = '0;
                            bad_cnt_d  = '0;
                        end else begin
                            bad_cnt_d = bad_cnt_q + 4'd1;
                        end
                    end
                end
                default: state_d = S_HUNT;
            endcase
        end
    end

    always_comb begin
        rx_word_d   = rx_word_q;
        align_cnt_d = align_cnt_q;
        rx_valid_d  = 1'b0;
        align_det_d = 1'b0;
        diff_err_d  = 1'b0;
        if (rx_en) begin
            diff_err_d = (rx_p == rx_n);
            unique case (state_q)
                S_HUNT:   align_det_d = match;
                S_VERIFY: align_det_d = boundary && match;
                S_LOCKED: begin
                    if (boundary) begin
                        rx_valid_d = 1'b1;
                        rx_word_d  = next_win;
                        if (match) begin
                            align_det_d = 1'b1;
                            if (align_cnt_q != 16'hFFFF)
                                align_cnt_d = align_cnt_q + 16'd1;
                        end
                    end
                end
                default: align_det_d = 1'b0;
            endcase
        end
    end

    assign rx_word   = rx_word_q;
    assign rx_valid  = rx_valid_q;
    assign align_det = align_det_q;
    assign locked    = (state_q == S_LOCKED);
    assign diff_err  = diff_err_q;
    assign align_cnt = align_cnt_q;

endmodule

// File: doc/mdl_alignp_receive.md
# mdl_alignp_receive

Bench receiver model for the serial ALIGNp link. It samples the differential line driven by the ALIGNp transmit model, deserializes it MSB-first, and hunts for the 40-bit ALIGNp pattern to find word alignment. After LOCK_CNT consecutive aligned ALIGNp words it declares lock. It then delivers every 40-bit word and drops lock after UNLOCK_CNT consecutive non-ALIGNp words.

## Interface

Parameters:
- LOCK_CNT, 4, consecutive aligned ALIGNp words needed to lock; legal range 1–15.
- UNLOCK_CNT, 2, consecutive mismatching words that drop lock; legal range 1–15.

Ports:
- clk  input  1  bit clock, one line bit sampled per rising edge.
- reset  input  1  asynchronous, active-high.
- rx_en  input  1  receive enable, mirrors the transmitter's burst_en.
- rx_p  input  1  line, positive leg.
- rx_n  input  1  line, negative leg.
- align_p  input  40  expected ALIGNp pattern, MSB transmitted first; static while rx_en=1.
- rx_word  output  40  last word captured at a word boundary while LOCKED.
- rx_valid  output  1  one-cycle pulse: rx_word updated.
- align_det  output  1  one-cycle pulse: aligned ALIGNp word recognised.
- locked  output  1  state==LOCKED.
- diff_err  output  1  one-cycle pulse: previous sample had rx_p == rx_n.
- align_cnt  output  16  ALIGNp words received while LOCKED, saturating at 16'hFFFF.

## Operation

- Sample: bit = rx_p when rx_p != rx_n, else 0 with diff_err=1. Sampling occurs only while rx_en=1.
- Window: 40-bit shift register, next_win = {win[38:0], bit}. All comparisons use next_win, so detection happens on the edge that samples the 40th bit.
- bit_cnt: 6 bits, 0..39, wraps 39→0. It defines word boundaries in VERIFY and LOCKED.
- States: HUNT, VERIFY, LOCKED.
- HUNT: compare on every sample. On next_win == align_p:
  - pulse align_det, bit_cnt←0, good_cnt←1.
  - go to VERIFY, or directly to LOCKED if LOCK_CNT==1.
- VERIFY: compare only when bit_cnt==39.
  - Match: pulse align_det, good_cnt+1. When good_cnt+1 == LOCK_CNT, go to LOCKED with bad_cnt←0.
  - Mismatch: go to HUNT, good_cnt←0. The failing sample does not trigger an immediate re-hunt match.
- LOCKED: at bit_cnt==39, rx_word←next_win and pulse rx_valid (every word, match or not).
  - Match: pulse align_det, bad_cnt←0, align_cnt saturating +1.
  - Mismatch: bad_cnt+1. When bad_cnt+1 == UNLOCK_CNT, go to HUNT and clear locked.
- diff_err does not change state directly; it only corrupts the sampled bit.
- rx_en=0 (synchronous): state←HUNT, win←0, bit_cnt←0, good_cnt←0, bad_cnt←0, locked←0. All pulses are 0. rx_word and align_cnt hold.
- Async reset: every output, counter, window and state is cleared. State←HUNT, rx_word←0, align_cnt←0.

## Timing

- All outputs are registered and update on the rising edge that samples the triggering bit. They are visible in the following cycle.
- Transmitter output is valid in the first cycle burst_en=1. With rx_en aligned to burst_en, edge n (n=1..) samples transmit bit 40−n of the word.
- First align_det: edge 40. Lock with LOCK_CNT=4: locked rises at edge 160.
- Word boundaries after lock fall every 40 edges; rx_valid is never asserted on consecutive cycles.
- Pulse outputs are one cycle wide.
- Mid-operation reset or rx_en drop takes effect on that edge; no partial word is reported.
- align_cnt at 16'hFFFF stays there.

## Test plan

- Reset, rx_en=1, transmitter sends align_p=40'hF3_5A5A_5A0C continuously → align_det at edges 40, 80, 120, 160; locked=1 after edge 160; rx_valid every 40 edges with rx_word=40'hF3_5A5A_5A0C; align_cnt increments per word.
- Receiver enabled 17 bits into the transmit stream (phase offset) → HUNT finds the pattern at the first true boundary; locked set 3 words later; no false align_det.
- While LOCKED, one word corrupted (bit 20 flipped) → rx_valid with corrupted rx_word, align_det absent, locked stays 1. Two consecutive corrupted words → locked=0 after the second boundary.
- Drive rx_p=rx_n=1 for one bit while locked → diff_err pulse; the word containing it mismatches; lock held (UNLOCK_CNT=2).
- Drop rx_en mid-word while locked → locked=0 next cycle, align_cnt holds. Re-enable aligned to burst_en → relock after 160 edges.
- Assert reset asynchronously mid-word → all outputs 0 immediately, align_cnt=0. Sim with LOCK_CNT=1 → locked at edge 40.
